eq_band_scaler: RTL and testbench

- Stage directly upstream of the equalizer output selector.
- Holds one programmable gain per filter band.
- On each sample strobe, multiplies every band's 24-bit left/right filter output by that band's gain, using one shared time-multiplexed multiplier.
- Presents saturated 48-bit per-band products on arrays that feed the selector's l_audio_din/r_audio_din inputs.

---
 rtl/eq_band_scaler.sv | 190 +++++++++++++++++++
 tb/tb_eq_band_scaler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_scaler.sv
// Per-band gain stage ahead of the EQ output selector: one shared multiplier
// walks L0,R0..L(N-1),R(N-1) each sample frame and writes saturated 48-bit products.

module eq_band_lane #(
  parameter logic [15:0] UNITY = 16'h4000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        gain_wr,
  input  logic [15:0] gain_in,
  input  logic        capture,
  input  logic [23:0] l_din,
  input  logic [23:0] r_din,
  input  logic        l_wr,
  input  logic        r_wr,
  input  logic [47:0] word,
  output logic [23:0] l_smp,
  output logic [23:0] r_smp,
  output logic [15:0] act_gain,
  output logic [47:0] l_dout,
  output logic [47:0] r_dout
);
  logic [15:0] gain;

  // act_gain snapshots the register value before any same-cycle write lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gain     <= UNITY;
      act_gain <= UNITY;
      l_smp    <= '0;
      r_smp    <= '0;
      l_dout   <= '0;
      r_dout   <= '0;
    end else begin
      if (gain_wr) gain <= gain_in;
      if (capture) begin
        l_smp    <= l_din;
        r_smp    <= r_din;
        act_gain <= gain;
      end
      if (l_wr) l_dout <= word;
      if (r_wr) r_dout <= word;
    end
  end
endmodule

module eq_band_scaler #(
  parameter int          num_of_filters = 4,
  parameter logic [15:0] unity_gain     = 16'h4000
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                eq_wr,
  input  logic [num_of_filters-1:0]           eq_wr_sel,
  input  logic [15:0]                         eq_gain,
  input  logic                                sample_valid,
  input  logic [num_of_filters-1:0][23:0]     l_band_din,
  input  logic [num_of_filters-1:0][23:0]     r_band_din,
  input  logic                                overrun_clr,
  output logic [num_of_filters-1:0][47:0]     l_audio_dout,
  output logic [num_of_filters-1:0][47:0]     r_audio_dout,
  output logic                                dout_valid,
  output logic                                busy,
  output logic                                overrun
);
  localparam int NW = 2 * num_of_filters;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);
  localparam logic signed [26:0] QMAX = 27'sd8388607;
  localparam logic signed [26:0] QMIN = -27'sd8388608;

  typedef enum logic [1:0] {IDLE, MUL, FLUSH} state_t;

  state_t                           state, state_nxt;
  logic [IW-1:0]                    idx;
  logic                             accept, ov_evt;
  logic [num_of_filters-1:0][23:0]  l_smp, r_smp;
  logic [num_of_filters-1:0][15:0]  act_gain;
  logic [num_of_filters-1:0]        l_wr, r_wr;
  logic signed [23:0]               op_smp;
  logic [15:0]                      op_gain;
  logic signed [40:0]               full_c, prod;
  logic [IW-1:0]                    prod_idx;
  logic                             prod_vld;
  logic signed [26:0]               q;
  logic [47:0]                      word;

  // A frame is refused in the dout_valid cycle as well as while busy
  assign busy   = (state != IDLE);
  assign accept = sample_valid && (state == IDLE) && !dout_valid;
  assign ov_evt = sample_valid && (busy || dout_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     if (idx == LAST) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          idx <= '0;
    else if (state == MUL && idx != LAST)  idx <= idx + 1'b1;
    else                                   idx <= '0;
  end

  // Even index = left, odd index = right of band idx/2
  always_comb begin
    op_smp  = '0;
    op_gain = '0;
    for (int k = 0; k < num_of_filters; k++) begin
      if (idx == IW'(2 * k)) begin
        op_smp  = l_smp[k];
        op_gain = act_gain[k];
      end
      if (idx == IW'(2 * k + 1)) begin
        op_smp  = r_smp[k];
        op_gain = act_gain[k];
      end
    end
  end

  assign full_c = op_smp * $signed({1'b0, op_gain});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod     <= '0;
      prod_idx <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod     <= full_c;
      prod_idx <= idx;
      prod_vld <= (state == MUL);
    end
  end

  // q is the product rescaled by 2^-14; fraction bits kept only when in range
  assign q = prod[40:14];

  always_comb begin
    if (q > QMAX)      word = {24'h7FFFFF, 24'h0};
    else if (q < QMIN) word = {24'h800000, 24'h0};
    else               word = {q[23:0], prod[13:0], 10'b0};
  end

  always_comb begin
    for (int k = 0; k < num_of_filters; k++) begin
      l_wr[k] = prod_vld && (prod_idx == IW'(2 * k));
      r_wr[k] = prod_vld && (prod_idx == IW'(2 * k + 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= (state == FLUSH);
      if (ov_evt)           overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  for (genvar k = 0; k < num_of_filters; k++) begin : g_lane
    eq_band_lane #(.UNITY(unity_gain)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .gain_wr  (eq_wr && eq_wr_sel[k]),
      .gain_in  (eq_gain),
      .capture  (accept),
      .l_din    (l_band_din[k]),
      .r_din    (r_band_din[k]),
      .l_wr     (l_wr[k]),
      .r_wr     (r_wr[k]),
      .word     (word),
      .l_smp    (l_smp[k]),
      .r_smp    (r_smp[k]),
      .act_gain (act_gain[k]),
      .l_dout   (l_audio_dout[k]),
      .r_dout   (r_audio_dout[k])
    );
  end
endmodule

// File: tb/tb_eq_band_scaler.sv
// Randomized bench for eq_band_scaler against a plain-arithmetic frame model.

module tb_eq_band_scaler;
  localparam int N = 4;
  localparam logic [15:0] UNITY = 16'h4000;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  eq_wr;
  logic [N-1:0]          eq_wr_sel;
  logic [15:0]           eq_gain;
  logic                  sample_valid;
  logic [N-1:0][23:0]    l_band_din, r_band_din;
  logic                  overrun_clr;
  logic [N-1:0][47:0]    l_audio_dout, r_audio_dout;
  logic                  dout_valid, busy, overrun;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] mgain [N];
  logic        exp_ov;

  eq_band_scaler #(.num_of_filters(N), .unity_gain(UNITY)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .eq_wr        (eq_wr),
    .eq_wr_sel    (eq_wr_sel),
    .eq_gain      (eq_gain),
    .sample_valid (sample_valid),
    .l_band_din   (l_band_din),
    .r_band_din   (r_band_din),
    .overrun_clr  (overrun_clr),
    .l_audio_dout (l_audio_dout),
    .r_audio_dout (r_audio_dout),
    .dout_valid   (dout_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scale by unsigned Q2.14 gain, clamp to 24-bit signed range
  function automatic logic [47:0] scale(input logic [23:0] d, input logic [15:0] g);
    longint full, q;
    full = longint'($signed(d)) * longint'(g);
    q    = full >>> 14;
    if (q > longint'(8388607))  return {24'h7FFFFF, 24'h0};
    if (q < -longint'(8388608)) return {24'h800000, 24'h0};
    return {q[23:0], full[13:0], 10'b0};
  endfunction

  function automatic logic [23:0] rnd_smp();
    case ($urandom_range(0, 5))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      2:       return 24'h0;
      3:       return 24'($urandom_range(0, 255));
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic rnd_inputs();
    for (int k = 0; k < N; k++) begin
      l_band_din[k] = rnd_smp();
      r_band_din[k] = rnd_smp();
    end
  endtask

  task automatic write_gain(input logic [N-1:0] sel, input logic [15:0] g);
    eq_wr = 1'b1; eq_wr_sel = sel; eq_gain = g;
    tick();
    eq_wr = 1'b0;
    for (int k = 0; k < N; k++) if (sel[k]) mgain[k] = g;
  endtask

  task automatic clear_ov();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    exp_ov = 1'b0;
    chk("overrun_clr", overrun, 0);
  endtask

  // Frame starts at c=0; optional extra sample_valid at ov_at, gain write at wr_at
  task automatic run_frame(input int ov_at = -1, input bit clr = 1'b0, input int wr_at = -1,
                           input logic [N-1:0] wsel = '0, input logic [15:0] wgain = '0);
    logic [47:0] el [N];
    logic [47:0] er [N];
    int c, busy_n;
    for (int k = 0; k < N; k++) begin
      el[k] = scale(l_band_din[k], mgain[k]);
      er[k] = scale(r_band_din[k], mgain[k]);
    end
    c = 0; busy_n = 0;
    forever begin
      sample_valid = (c == 0) || (c == ov_at);
      overrun_clr  = clr && (c == ov_at);
      eq_wr        = (c == wr_at);
      eq_wr_sel    = wsel;
      eq_gain      = wgain;
      if (c == 1) rnd_inputs();
      if (c > 0 && busy) busy_n++;
      if (dout_valid || c >= 40) break;
      if (c == wr_at) for (int k = 0; k < N; k++) if (wsel[k]) mgain[k] = wgain;
      if (c == ov_at && c > 0) exp_ov = 1'b1;
      tick();
      c++;
    end
    chk("latency", c, 2 * N + 2);
    chk("busy_cycles", busy_n, 2 * N + 1);
    chk("overrun", overrun, exp_ov);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("l_dout%0d", k), l_audio_dout[k], el[k]);
      chk($sformatf("r_dout%0d", k), r_audio_dout[k], er[k]);
    end
    tick();
    if (c == ov_at) exp_ov = 1'b1;
    sample_valid = 1'b0; overrun_clr = 1'b0; eq_wr = 1'b0;
    chk("dout_valid_pulse", dout_valid, 0);
    chk("idle_after", busy, 0);
    chk("overrun_post", overrun, exp_ov);
  endtask

  initial begin
    int dv_n;
    reset_n = 1'b0; eq_wr = 1'b0; eq_wr_sel = '0; eq_gain = '0;
    sample_valid = 1'b0; overrun_clr = 1'b0;
    l_band_din = '0; r_band_din = '0;
    for (int k = 0; k < N; k++) mgain[k] = UNITY;
    exp_ov = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_overrun", overrun, 0);
    for (int k = 0; k < N; k++) begin
      chk("rst_l_dout", l_audio_dout[k], 0);
      chk("rst_r_dout", r_audio_dout[k], 0);
    end

    // Unity gains straight out of reset
    l_band_din[0] = 24'h100000;
    r_band_din[3] = 24'hF00000;
    run_frame();
    chk("t1_l0", l_audio_dout[0], 48'h100000_000000);
    chk("t1_r3", r_audio_dout[3], 48'hF00000_000000);

    // Selective writes; an empty select writes nothing
    write_gain(4'b0010, 16'h8000);
    write_gain(4'b0100, 16'h2000);
    write_gain(4'b0000, 16'h0000);
    for (int k = 0; k < N; k++) begin
      l_band_din[k] = 24'h200000;
      r_band_din[k] = 24'h200000;
    end
    run_frame();
    chk("t2_l1", l_audio_dout[1][47:24], 24'h400000);
    chk("t2_r2", r_audio_dout[2][47:24], 24'h100000);
    chk("t2_l0", l_audio_dout[0][47:24], 24'h200000);

    // Saturation both ways
    write_gain(4'b1111, 16'hFFFF);
    for (int k = 0; k < N; k++) begin
      l_band_din[k] = 24'h000010;
      r_band_din[k] = 24'h000010;
    end
    l_band_din[0] = 24'h7FFFFF;
    r_band_din[0] = 24'h800000;
    run_frame();
    chk("t3_l0", l_audio_dout[0], 48'h7FFFFF_000000);
    chk("t3_r0", r_audio_dout[0], 48'h800000_000000);
    chk("t3_l2", l_audio_dout[2][47:24], 24'h00003F);

    // Overrun: mid-frame, with simultaneous clear, and in the dout_valid cycle
    write_gain(4'b1111, UNITY);
    run_frame(3);
    clear_ov();
    run_frame(3, 1'b1);
    clear_ov();
    run_frame(2 * N + 2);
    clear_ov();

    // Gain write during the frame applies only to the next one
    l_band_din[0] = 24'h100000;
    run_frame(-1, 1'b0, 2, 4'b0001, 16'h0000);
    chk("t5_cur", l_audio_dout[0], 48'h100000_000000);
    run_frame();
    chk("t5_next", l_audio_dout[0], 0);

    // Reset in the middle of a frame
    rnd_inputs();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_dout_valid", dout_valid, 0);
    for (int k = 0; k < N; k++) begin
      chk("mrst_l_dout", l_audio_dout[k], 0);
      chk("mrst_r_dout", r_audio_dout[k], 0);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < N; k++) mgain[k] = UNITY;
    exp_ov = 1'b0;
    dv_n = 0;
    repeat (15) begin
      tick();
      if (dout_valid) dv_n++;
    end
    chk("mrst_no_dv", dv_n, 0);
    l_band_din[0] = 24'h123456;
    run_frame();

    // Random back-to-back frames with random writes and collisions
    for (int i = 0; i < 20; i++) begin
      int ov, wr;
      repeat ($urandom_range(0, 2)) write_gain(N'($urandom), 16'($urandom));
      rnd_inputs();
      ov = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * N + 2) : -1;
      wr = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * N + 1) : -1;
      run_frame(ov, 1'($urandom), wr, N'($urandom), 16'($urandom));
      if (exp_ov && $urandom_range(0, 1) == 1) clear_ov();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
